cache_bus_engine: RTL

- Second-generation cache-side AHB master; replaces the fixed 8-bit, read-burst-only unit.
- Executes single read, single write, line refill (read burst) and line write-back (write burst) for the cache controller.
- Parametrised in data width, address width and line length, with full AHB address/data pipelining, wait states, two-cycle ERROR abort and hsize support.
- Sits between the cache controller/line SRAM and the shared AHB arbiter.

---
 rtl/cache_bus_pkg.sv | 44 ++++
 rtl/cache_bus_beat_ctr.sv | 49 ++++
 rtl/cache_bus_engine.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cache_bus_pkg.sv
// Shared definitions for the cache-side AHB master.
// Holds the AHB htrans/hburst encodings, the controller request opcodes,
// the engine state encoding and the line-burst type selection helper.
package cache_bus_pkg;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [1:0] OP_READ_SINGLE  = 2'b00;
    localparam logic [1:0] OP_WRITE_SINGLE = 2'b01;
    localparam logic [1:0] OP_READ_LINE    = 2'b10;
    localparam logic [1:0] OP_WRITE_LINE   = 2'b11;

    // Engine state encoding, kept as plain constants so existing
    // waveform decoders and checkers keep working.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ARB   = 3'd1;
    localparam state_t ST_ADDR  = 3'd2;
    localparam state_t ST_BURST = 3'd3;
    localparam state_t ST_LAST  = 3'd4;
    localparam state_t ST_ERR1  = 3'd5;
    localparam state_t ST_ERR2  = 3'd6;

    // Fixed-length INCRx only exists for 4/8/16 beats; everything else
    // falls back to an undefined-length INCR.
    function automatic logic [2:0] line_burst(input int line_beats, input bit fixed_burst);
        if (!fixed_burst) return HBURST_INCR;
        case (line_beats)
            4:       return HBURST_INCR4;
            8:       return HBURST_INCR8;
            16:      return HBURST_INCR16;
            default: return HBURST_INCR;
        endcase
    endfunction

endpackage

// File: rtl/cache_bus_beat_ctr.sv
// Address-beat and data-beat counters for one line transfer.
// Ports:
//   clear      - restart both counters at beat 0 (held while arbitrating)
//   single     - single transfer: both phases are their own last beat
//   addr_adv   - an address phase was accepted this cycle
//   data_adv   - a data phase completed this cycle
//   addr_beat  - beat currently on the address bus
//   data_beat  - beat currently in its data phase
//   addr_last  - addr_beat is the final beat
//   data_last  - data_beat is the final beat
module cache_bus_beat_ctr #(
    parameter int LINE_BEATS = 8,
    parameter int BW = $clog2(LINE_BEATS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          single,
    input  logic          addr_adv,
    input  logic          data_adv,
    output logic [BW-1:0] addr_beat,
    output logic [BW-1:0] data_beat,
    output logic          addr_last,
    output logic          data_last
);

    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);

    assign addr_last = single || (addr_beat == LAST_BEAT);
    assign data_last = single || (data_beat == LAST_BEAT);

    // Counters saturate on the final beat instead of wrapping, so a late
    // advance can never alias back onto beat 0.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            addr_beat <= '0;
            data_beat <= '0;
        end else if (clear) begin
            addr_beat <= '0;
            data_beat <= '0;
        end else begin
            if (addr_adv && !addr_last) addr_beat <= addr_beat + 1'b1;
            if (data_adv && !data_last) data_beat <= data_beat + 1'b1;
        end
    end

endmodule

// File: rtl/cache_bus_engine.sv
// Cache-side AHB master: single read/write, line refill and line write-back.
// Ports:
//   req_*        - controller request, held until done or err
//   rdata/done/err - completion results back to the controller
//   line_*       - line SRAM side (refill writes, write-back reads, 1-cycle latency)
//   bus_req/bus_ack - shared arbiter handshake
//   h*           - AHB master interface
module cache_bus_engine
    import cache_bus_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int LINE_BEATS = 8,
    parameter bit FIXED_BURST = 1'b1,
    localparam int BW = $clog2(LINE_BEATS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [2:0]    req_size,
    input  logic [DW-1:0] req_wdata,
    output logic [DW-1:0] rdata,
    output logic          done,
    output logic          err,
    output logic [BW-1:0] line_idx,
    output logic          line_we,
    output logic          line_rd_en,
    input  logic [DW-1:0] line_rdata,
    output logic [DW-1:0] line_wdata,
    output logic          bus_req,
    input  logic          bus_ack,
    output logic [AW-1:0] haddr,
    output logic          hwrite,
    output logic [2:0]    hsize,
    output logic [2:0]    hburst,
    output logic [1:0]    htrans,
    output logic [DW-1:0] hwdata,
    input  logic          hready,
    input  logic          hresp,
    input  logic [DW-1:0] hrdata
);

    localparam int SZ = $clog2(DW / 8);
    localparam int OFF = BW + SZ;
    localparam logic [2:0] LINE_HBURST = line_burst(LINE_BEATS, FIXED_BURST);

    state_t        state;
    logic [1:0]    op_q;
    logic [AW-1:0] addr_q;
    logic [2:0]    size_q;
    logic [DW-1:0] wdata_q;
    logic [1:0]    htrans_q;
    logic          data_active;

    logic [BW-1:0] addr_beat, data_beat, next_beat;
    logic          addr_last, data_last;
    logic          is_line, is_write, addr_phase, grant;
    logic          err_now, addr_acc, data_done;
    logic [AW-1:0] line_base, beat_addr;

    assign is_line    = op_q[1];
    assign is_write   = op_q[0];
    assign addr_phase = (state == ST_ADDR) || (state == ST_BURST);
    assign grant      = (state == ST_ARB) && bus_ack;

    // An error response outranks everything else in the same cycle: the
    // pending address is not accepted and the beat does not complete.
    assign err_now   = data_active && hresp;
    assign addr_acc  = addr_phase && hready && !err_now;
    assign data_done = data_active && hready && !hresp;

    assign next_beat = addr_beat + 1'b1;
    assign line_base = {addr_q[AW-1:OFF], {OFF{1'b0}}};
    assign beat_addr = line_base | ({{(AW - BW){1'b0}}, next_beat} << SZ);

    // The error cancel must reach the bus in the first error cycle, before
    // the registered htrans can react.
    assign htrans     = err_now ? HTRANS_IDLE : htrans_q;
    assign line_wdata = hrdata;
    assign line_we    = data_done && (op_q == OP_READ_LINE);
    // Write-back prefetches word k+1 as beat k is accepted so it is waiting
    // in the SRAM output register when beat k+1 is accepted.
    assign line_rd_en = (op_q == OP_WRITE_LINE) && (grant || (addr_acc && !addr_last));
    assign line_idx   = (op_q == OP_READ_LINE) ? data_beat
                      : (state == ST_ARB) ? '0 : next_beat;

    cache_bus_beat_ctr #(.LINE_BEATS(LINE_BEATS)) u_beat_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state == ST_ARB),
        .single    (!is_line),
        .addr_adv  (addr_acc),
        .data_adv  (data_done),
        .addr_beat (addr_beat),
        .data_beat (data_beat),
        .addr_last (addr_last),
        .data_last (data_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op_q        <= OP_READ_SINGLE;
            addr_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            data_active <= 1'b0;
            haddr       <= '0;
            hwrite      <= 1'b0;
            hsize       <= '0;
            hburst      <= HBURST_SINGLE;
            hwdata      <= '0;
            rdata       <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            bus_req     <= 1'b0;
        end else begin
            // done/err are single-cycle pulses; only a transition raises them.
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // The controller still holds req_valid during the done
                    // cycle, so that cycle must not start a new request.
                    if (req_valid && !done) begin
                        op_q    <= req_op;
                        addr_q  <= req_addr;
                        size_q  <= req_size;
                        wdata_q <= req_wdata;
                        bus_req <= 1'b1;
                        state   <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (bus_ack) begin
                        state    <= ST_ADDR;
                        htrans_q <= HTRANS_NSEQ;
                        hwrite   <= is_write;
                        haddr    <= is_line ? line_base : addr_q;
                        hsize    <= is_line ? 3'(SZ) : size_q;
                        hburst   <= is_line ? LINE_HBURST : HBURST_SINGLE;
                    end
                end
                ST_ADDR, ST_BURST, ST_LAST: begin
                    if (err_now) begin
                        state       <= ST_ERR1;
                        htrans_q    <= HTRANS_IDLE;
                        data_active <= 1'b0;
                    end else if (addr_acc) begin
                        data_active <= 1'b1;
                        if (is_write) hwdata <= is_line ? line_rdata : wdata_q;
                        if (addr_last) begin
                            state    <= ST_LAST;
                            htrans_q <= HTRANS_IDLE;
                        end else begin
                            state    <= ST_BURST;
                            htrans_q <= HTRANS_SEQ;
                            haddr    <= beat_addr;
                        end
                    end else if (state == ST_LAST && data_done && data_last) begin
                        data_active <= 1'b0;
                        done        <= 1'b1;
                        bus_req     <= 1'b0;
                        state       <= ST_IDLE;
                        if (op_q == OP_READ_SINGLE) rdata <= hrdata;
                    end
                end
                ST_ERR1: begin
                    if (hready) begin
                        state   <= ST_ERR2;
                        err     <= 1'b1;
                        bus_req <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The arbiter must not withdraw the grant while we drive address phases.
    a_grant_held: assert property (@(posedge clk) disable iff (!rst_n) addr_phase |-> bus_ack);

endmodule
